// File: rtl/uart_cmd_parser_pkg.sv
// Shared types and constants for the UART command framer.
// Frame layout is SYNC, OP, ARG, CHK with CHK = OP ^ ARG.
package uart_cmd_parser_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    GET_OP  = 2'd1,
    GET_ARG = 2'd2,
    GET_CHK = 2'd3
  } state_t;

  localparam logic [7:0] SYNC_DEF  = 8'hA5;
  localparam int         FRAME_LEN = 4;

  function automatic logic [7:0] cmd_chk(
    input logic [7:0] op,
    input logic [7:0] arg
  );
    return op ^ arg;
  endfunction

endpackage

// File: rtl/uart_cmd_parser_fifo.sv
// Synchronous command FIFO with registered head outputs.
// A push into a full FIFO succeeds only alongside a pop.
module cmd_fifo #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic [15:0] din,
  input  logic        pop,
  output logic        full,
  output logic        valid,
  output logic [15:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_d;
  logic [15:0]   head_d;
  logic          do_pop;
  logic          do_push;

  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && (count != '0);
  assign do_push = push && (!full || do_pop);

  always_comb begin
    count_d = count;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count + 1'b1;
      2'b01:   count_d = count - 1'b1;
      default: count_d = count;
    endcase
  end

  // Next head: the following entry on pop, or the incoming word if it lands at the head.
  always_comb begin
    head_d = head;
    if (do_pop) begin
      if (count > (AW+1)'(1))
        head_d = mem[rd_ptr + 1'b1];
      else if (do_push)
        head_d = din;
    end else if (count == '0 && do_push) begin
      head_d = din;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      valid  <= 1'b0;
      head   <= '0;
    end else begin
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      count <= count_d;
      valid <= (count_d != '0);
      head  <= head_d;
    end
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// Frames UART bytes into 4-byte commands, validates them
// and queues good ones; bad, stalled or dropped frames are counted.
module uart_cmd_parser
  import uart_cmd_parser_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE   = SYNC_DEF,
  parameter int         TIMEOUT_CYC = 1_000_000,
  parameter int         TMR_W       = 20,
  parameter int         FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_ready,
  output logic       cmd_valid,
  output logic [7:0] cmd_op,
  output logic [7:0] cmd_arg,
  input  logic       cmd_ready,
  output logic       frame_err,
  output logic       overflow,
  output logic [7:0] err_count
);

  state_t           state;
  state_t           state_d;
  logic [TMR_W-1:0] timer;
  logic [7:0]       op_q;
  logic [7:0]       arg_q;
  logic             tmo;
  logic             chk_ok;
  logic             push_d;
  logic             err_d;
  logic             push_q;
  logic [15:0]      push_data;
  logic             fifo_full;
  logic             pop;
  logic             ovf_d;
  logic [15:0]      head;

  // A byte in the timeout cycle wins over the timeout.
  assign tmo = (state != HUNT) && !rx_ready
            && (timer == TMR_W'(TIMEOUT_CYC - 1));
  assign chk_ok = (rx_data == cmd_chk(op_q, arg_q));
  assign pop    = cmd_ready && cmd_valid;
  assign ovf_d  = push_q && fifo_full && !pop;

  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= HUNT;
    else
      state <= state_d;
  end

  always_comb begin
    state_d = state;
    if (tmo) begin
      state_d = HUNT;
    end else if (rx_ready) begin
      unique case (state)
        HUNT:    if (rx_data == SYNC_BYTE) state_d = GET_OP;
        GET_OP:  state_d = GET_ARG;
        GET_ARG: state_d = GET_CHK;
        GET_CHK: state_d = HUNT;
        default: state_d = HUNT;
      endcase
    end
  end

  always_comb begin
    push_d = 1'b0;
    err_d  = tmo;
    if (rx_ready && state == GET_CHK) begin
      push_d = chk_ok;
      err_d  = !chk_ok;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timer     <= '0;
      op_q      <= '0;
      arg_q     <= '0;
      push_q    <= 1'b0;
      push_data <= '0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
      err_count <= '0;
    end else begin
      if (rx_ready || state == HUNT || tmo)
        timer <= '0;
      else
        timer <= timer + 1'b1;
      if (rx_ready && state == GET_OP)
        op_q <= rx_data;
      if (rx_ready && state == GET_ARG)
        arg_q <= rx_data;
      push_q    <= push_d;
      push_data <= {op_q, arg_q};
      frame_err <= err_d;
      overflow  <= ovf_d;
      if ((err_d || ovf_d) && err_count != 8'hFF)
        err_count <= err_count + 1'b1;
    end
  end

  cmd_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push_q),
    .din  (push_data),
    .pop  (cmd_ready),
    .full (fifo_full),
    .valid(cmd_valid),
    .head (head)
  );

  assign cmd_op  = head[15:8];
  assign cmd_arg = head[7:0];

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: frame table plus
// timeout, overflow, reset and saturation sequences.
module tb_uart_cmd_parser;

  localparam int TMO = 40;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       cmd_valid;
  logic [7:0] cmd_op;
  logic [7:0] cmd_arg;
  logic       cmd_ready;
  logic       frame_err;
  logic       overflow;
  logic [7:0] err_count;

  int total = 0;
  int bad   = 0;
  int exp_err = 0;

  typedef struct {
    logic [7:0] op;
    logic [7:0] arg;
    logic [7:0] chk;
    logic       good;
  } vec_t;

  vec_t vecs[7];

  uart_cmd_parser #(
    .SYNC_BYTE  (8'hA5),
    .TIMEOUT_CYC(TMO),
    .TMR_W      (20),
    .FIFO_DEPTH (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_data  (rx_data),
    .rx_ready (rx_ready),
    .cmd_valid(cmd_valid),
    .cmd_op   (cmd_op),
    .cmd_arg  (cmd_arg),
    .cmd_ready(cmd_ready),
    .frame_err(frame_err),
    .overflow (overflow),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // One strobe; returns at the negedge after the sampling edge.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] op,
                            input logic [7:0] arg,
                            input logic [7:0] c);
    send_byte(8'hA5);
    send_byte(op);
    send_byte(arg);
    send_byte(c);
  endtask

  task automatic pop_one();
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
  endtask

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'h12, 8'h34, 8'h26, 1'b1};
    vecs[1] = '{8'h12, 8'h34, 8'h00, 1'b0};
    vecs[2] = '{8'h01, 8'h02, 8'h03, 1'b1};
    vecs[3] = '{8'hA5, 8'h00, 8'hA5, 1'b1};
    vecs[4] = '{8'hFF, 8'hFF, 8'h00, 1'b1};
    vecs[5] = '{8'h00, 8'h00, 8'h01, 1'b0};
    vecs[6] = '{8'h5A, 8'hA5, 8'hFF, 1'b1};

    rst_n = 1'b0;
    rx_data = '0;
    rx_ready = 1'b0;
    cmd_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_valid", cmd_valid, 0);
    chk("rst_op", cmd_op, 0);
    chk("rst_arg", cmd_arg, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_cnt", err_count, 0);

    // Frame table
    for (int i = 0; i < 7; i++) begin
      send_frame(vecs[i].op, vecs[i].arg, vecs[i].chk);
      if (!vecs[i].good) exp_err++;
      chk("tbl_ferr", frame_err, !vecs[i].good);
      chk("tbl_valid0", cmd_valid, 0);
      chk("tbl_cnt", err_count, exp_err);
      @(negedge clk);
      chk("tbl_ferr1", frame_err, 0);
      chk("tbl_valid1", cmd_valid, vecs[i].good);
      if (vecs[i].good) begin
        chk("tbl_op", cmd_op, vecs[i].op);
        chk("tbl_arg", cmd_arg, vecs[i].arg);
      end
      pop_one();
      chk("tbl_popped", cmd_valid, 0);
    end

    // Noise, then a stalled frame that times out
    send_byte(8'h00);
    chk("noise00", frame_err, 0);
    send_byte(8'hFF);
    chk("noiseFF", frame_err, 0);
    send_byte(8'hA5);
    send_byte(8'h01);
    for (int k = 1; k < TMO; k++) begin
      @(negedge clk);
      chk("tmo_early", frame_err, 0);
    end
    @(negedge clk);
    exp_err++;
    chk("tmo_ferr", frame_err, 1);
    chk("tmo_cnt", err_count, exp_err);
    @(negedge clk);
    chk("tmo_pulse", frame_err, 0);
    send_frame(8'h12, 8'h34, 8'h26);
    @(negedge clk);
    chk("tmo_hunt_v", cmd_valid, 1);
    chk("tmo_hunt_op", cmd_op, 8'h12);
    pop_one();

    // Byte exactly in the timeout cycle is accepted
    send_byte(8'hA5);
    send_byte(8'h01);
    repeat (TMO - 2) @(negedge clk);
    send_byte(8'h02);
    chk("tmo_edge", frame_err, 0);
    send_byte(8'h03);
    chk("tmo_edge_chk", frame_err, 0);
    @(negedge clk);
    chk("tmo_edge_v", cmd_valid, 1);
    chk("tmo_edge_arg", cmd_arg, 8'h02);
    chk("tmo_edge_cnt", err_count, exp_err);
    pop_one();

    // Overflow with FIFO full
    for (int f = 0; f < 5; f++)
      send_frame(8'h10 + 8'(f), 8'h20 + 8'(f), 8'h30);
    chk("ovf_before", overflow, 0);
    @(negedge clk);
    exp_err++;
    chk("ovf_pulse", overflow, 1);
    chk("ovf_cnt", err_count, exp_err);
    @(negedge clk);
    chk("ovf_pulse1", overflow, 0);
    for (int f = 0; f < 4; f++) begin
      chk("ovf_v", cmd_valid, 1);
      chk("ovf_op", cmd_op, 8'h10 + 8'(f));
      chk("ovf_arg", cmd_arg, 8'h20 + 8'(f));
      pop_one();
    end
    chk("ovf_empty", cmd_valid, 0);

    // Same, but a pop in the push cycle makes room
    for (int f = 0; f < 5; f++)
      send_frame(8'h40 + 8'(f), 8'h50 + 8'(f), 8'h10);
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    chk("nov_pulse", overflow, 0);
    chk("nov_cnt", err_count, exp_err);
    for (int f = 1; f < 5; f++) begin
      chk("nov_v", cmd_valid, 1);
      chk("nov_op", cmd_op, 8'h40 + 8'(f));
      pop_one();
    end
    chk("nov_empty", cmd_valid, 0);

    // Reset mid-frame with a queued command
    send_frame(8'h77, 8'h01, 8'h76);
    send_byte(8'hA5);
    send_byte(8'h12);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_err = 0;
    chk("mrst_valid", cmd_valid, 0);
    chk("mrst_op", cmd_op, 0);
    chk("mrst_arg", cmd_arg, 0);
    chk("mrst_cnt", err_count, 0);
    send_byte(8'h34);
    send_byte(8'h26);
    chk("mrst_ferr", frame_err, 0);
    @(negedge clk);
    chk("mrst_ferr1", frame_err, 0);
    chk("mrst_nov", cmd_valid, 0);

    // Saturation
    for (int n = 0; n < 300; n++) begin
      send_frame(8'h12, 8'h34, 8'h00);
      exp_err = sat(exp_err + 1);
      if (n == 253 || n == 254 || n == 299)
        chk("sat_cnt", err_count, exp_err);
    end
    chk("sat_final", err_count, 255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_cmd_parser.md
# uart_cmd_parser

Frames the byte stream coming out of the UART receiver into fixed 4-byte game commands (sync, opcode, argument, checksum) and buffers validated commands in a small FIFO for the game controller. Sits directly downstream of the UART byte receiver, consuming its byte/strobe pair, and upstream of the tile/game logic, which drains commands through a valid/ready handshake. Malformed, stalled or overflowing frames are discarded and counted.

## Interface
- SYNC_BYTE, 8'hA5, first byte of every frame
- TIMEOUT_CYC, 1_000_000, max CLK cycles between bytes inside a frame (10 ms @ 100 MHz)
- TMR_W, 20, width of inter-byte timer; must hold TIMEOUT_CYC
- FIFO_DEPTH, 4, command FIFO entries; power of two, ≥2
- CLK  input  1  system clock, 100 MHz; the only clock
- RST_N  input  1  reset, synchronous, active-low
- RX_DATA  input  8  received byte; valid only while RX_READY=1
- RX_READY  input  1  one-cycle strobe, one byte per strobe
- CMD_VALID  output  1  FIFO non-empty
- CMD_OP  output  8  opcode at FIFO head
- CMD_ARG  output  8  argument at FIFO head
- CMD_READY  input  1  consumer pops head when CMD_VALID & CMD_READY
- FRAME_ERR  output  1  one-cycle pulse: checksum fail or timeout
- OVERFLOW  output  1  one-cycle pulse: valid frame dropped, FIFO full
- ERR_COUNT  output  8  saturating count of FRAME_ERR + OVERFLOW events

## Operation
- Frame: SYNC_BYTE, OP, ARG, CHK; valid iff CHK == OP ^ ARG.
- FSM states: HUNT, GET_OP, GET_ARG, GET_CHK. All transitions occur only on RX_READY, except timeout.
- HUNT: byte == SYNC_BYTE -> GET_OP; any other byte ignored silently (no error).
- GET_OP: latch OP -> GET_ARG. GET_ARG: latch ARG -> GET_CHK. SYNC_BYTE value in these positions is plain data; no resync.
- GET_CHK: checksum good -> push {OP,ARG} (or OVERFLOW if no room) -> HUNT; bad -> FRAME_ERR -> HUNT.
- Timeout: timer cleared on every RX_READY and in HUNT; increments each cycle otherwise; reaching TIMEOUT_CYC in GET_OP/GET_ARG/GET_CHK -> FRAME_ERR, HUNT, timer cleared.
- RX_READY in the same cycle the timer reaches TIMEOUT_CYC: byte wins, no timeout.
- FIFO: push refused only if full and no pop in the same cycle; push and pop together when full succeed (count unchanged). Pop on empty ignored. Pointers wrap modulo FIFO_DEPTH; count is log2(FIFO_DEPTH)+1 bits.
- ERR_COUNT increments by 1 per FRAME_ERR or OVERFLOW pulse (never both in one cycle); holds at 255.
- Reset (RST_N=0 at a CLK edge, any state, mid-frame included): state HUNT, timer 0, FIFO emptied, CMD_VALID=0, CMD_OP=0, CMD_ARG=0, FRAME_ERR=0, OVERFLOW=0, ERR_COUNT=0. Partial frame lost, no error reported.

## Timing
- All outputs registered; no combinational path from RX_* or CMD_READY to any output.
- CHK strobe at edge N -> entry written at edge N+1 -> CMD_VALID=1 with head data from edge N+1 (1-cycle latency when empty).
- FRAME_ERR / OVERFLOW asserted exactly one cycle, the cycle after the causing strobe or timeout edge; ERR_COUNT updates the same cycle.
- Pop at edge M: next entry (or CMD_VALID=0) visible after edge M. CMD_OP/CMD_ARG stable while CMD_VALID=1 and not popped.
- Back-to-back RX_READY on consecutive cycles must be handled (no minimum byte spacing assumed).

## Structure
- Shared package/include: FSM state encoding (2-bit HUNT=0, GET_OP=1, GET_ARG=2, GET_CHK=3), default SYNC_BYTE, frame length constant 4.
- One sub-module: cmd_fifo (synchronous FIFO, width 16, depth FIFO_DEPTH, registered head outputs, full/empty/simultaneous push-pop as above). Framing FSM, timer and error counter stay in the top.

## Test plan
- Frame A5,12,34,26 with CMD_READY=0 -> CMD_VALID=1 one cycle after CHK strobe, CMD_OP=12, CMD_ARG=34, no FRAME_ERR; assert CMD_READY -> CMD_VALID=0 next cycle.
- Frame A5,12,34,00 -> FRAME_ERR one pulse, ERR_COUNT=1, CMD_VALID stays 0; following good frame A5,01,02,03 accepted.
- Bytes 00,FF,A5,01 then silence TIMEOUT_CYC cycles -> no error for 00/FF, one FRAME_ERR at timeout, state HUNT; byte arriving exactly at timeout cycle -> no error.
- Five good frames, CMD_READY=0, FIFO_DEPTH=4 -> four stored in order, fifth gives OVERFLOW, ERR_COUNT=1; repeat with CMD_READY=1 on fifth CHK cycle+1 -> no OVERFLOW.
- RST_N low after A5,12 -> all outputs reset values; then 34,26 ignored (HUNT), no CMD_VALID, no FRAME_ERR.
- 300 bad-checksum frames -> ERR_COUNT saturates at 255.
